// File: rtl/register_unit_sb.sv
// register_unit_sb: two-write-port register file with read bypass, busy scoreboard and clear-after-reset
module register_unit_sb #(
    parameter int XLEN = 32,
    parameter int NREGS = 32,
    localparam int AW = $clog2(NREGS),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] RURs1,
    output logic [XLEN-1:0] RURs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] DataWr,
    input  logic            RUWr,
    input  logic [AW-1:0]   rd2,
    input  logic [XLEN-1:0] DataWr2,
    input  logic            RUWr2,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_rd,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            ready
);
    typedef enum logic {INIT, RUN} state_t;
    state_t state;
    logic [AW-1:0] cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] busy;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            cnt <= '0;
            busy <= '0;
            ready <= 1'b0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (CLEAR_ON_RESET == 0 || cnt == AW'(NREGS - 1)) begin
                state <= RUN;
                ready <= 1'b1;
            end
        end else begin
            if (RUWr2) busy[rd2] <= 1'b0;
            // set is issued after clear so a same-index collision leaves the bit set
            if (busy_set && busy_rd != '0) busy[busy_rd] <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                if (CLEAR_ON_RESET != 0) regs[cnt] <= '0;
            end else begin
                if (RUWr2 && rd2 != '0) regs[rd2] <= DataWr2;
                if (RUWr && rd != '0) regs[rd] <= DataWr;
            end
        end
    end
    assign RURs1 = (!ready || rs1 == '0) ? '0 : (RUWr && rd == rs1) ? DataWr :
                   (RUWr2 && rd2 == rs1) ? DataWr2 : regs[rs1];
    assign RURs2 = (!ready || rs2 == '0) ? '0 : (RUWr && rd == rs2) ? DataWr :
                   (RUWr2 && rd2 == rs2) ? DataWr2 : regs[rs2];
    assign rs1_busy = ready && rs1 != '0 && busy[rs1] && !(RUWr2 && rd2 == rs1);
    assign rs2_busy = ready && rs2 != '0 && busy[rs2] && !(RUWr2 && rd2 == rs2);
endmodule

// File: doc/register_unit_sb.md
# register_unit_sb

Parametrised register unit for the pipelined CPU: multi-ported register array with register 0 hardwired to zero and two write ports (ALU writeback and late load/multi-cycle writeback). It adds same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential clear-on-reset engine with a `ready` flag. It sits between decode (reads) and writeback (writes), replacing the single-write-port unit.

## Interface
Parameters:
- `XLEN`, 32, data width in bits.
- `NREGS`, 32, number of registers; power of two, ≥ 2.
- `AW`, `$clog2(NREGS)`, register index width; derived, not overridden.
- `CLEAR_ON_RESET`, 1, 1 = zero all registers after reset; 0 = keep contents.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `rs1` in `AW`: read index, port 1.
- `rs2` in `AW`: read index, port 2.
- `RURs1` out `XLEN`: read data, port 1.
- `RURs2` out `XLEN`: read data, port 2.
- `rd` in `AW`: write index, primary port.
- `DataWr` in `XLEN`: write data, primary port.
- `RUWr` in 1: write enable, primary port.
- `rd2` in `AW`: write index, secondary port.
- `DataWr2` in `XLEN`: write data, secondary port.
- `RUWr2` in 1: write enable, secondary port; also clears the busy bit of `rd2`.
- `busy_set` in 1: mark `busy_rd` as pending.
- `busy_rd` in `AW`: register to mark busy.
- `rs1_busy` out 1: `rs1` has a pending write.
- `rs2_busy` out 1: `rs2` has a pending write.
- `ready` out 1: unit accepts writes and returns valid reads.

## Operation
- States are INIT and RUN.
- **Reset:** `rst_n` low at an edge forces INIT, clear counter to 0, all busy bits to 0 and `ready` to 0. Array contents are untouched by reset itself.
- **INIT with `CLEAR_ON_RESET=1`:** each edge with `rst_n` high writes 0 to `reg[cnt]` and increments `cnt`. The edge that clears `NREGS-1` moves to RUN and sets `ready`.
- **INIT with `CLEAR_ON_RESET=0`:** the first edge with `rst_n` high moves to RUN and sets `ready`.
- **Ignored inputs while not `ready`:** all writes and `busy_set`. Read outputs and busy outputs are forced to 0.
- **Register 0:** always reads 0. Writes to index 0 are dropped, and its busy bit never sets.
- **Writes (RUN):** on each edge, `reg[rd] <= DataWr` if `RUWr`, and `reg[rd2] <= DataWr2` if `RUWr2`. If both ports target the same nonzero index, the primary port (`DataWr`) wins.
- **Reads:** combinational, with bypass. Priority order:
  - index 0 gives 0;
  - `RUWr && rd==rsX` gives `DataWr`;
  - `RUWr2 && rd2==rsX` gives `DataWr2`;
  - otherwise the array value.
- **Scoreboard:**
  - `busy_set` sets `busy[busy_rd]`.
  - `RUWr2` clears `busy[rd2]`.
  - If set and clear hit the same index in one cycle, set wins.
  - The primary port never changes busy bits.
- **Busy outputs:** `rsX_busy = busy[rsX] & ~(RUWr2 && rd2==rsX)`, i.e. the clear is bypassed in the same cycle. Index 0 always reports 0.
- **Reset mid-operation:** reset during INIT restarts clearing at register 0. Reset during RUN clears the scoreboard, drops `ready` on that edge, and re-enters INIT.

## Timing
- Read latency is 0 cycles (combinational from `rsX`, write ports, array and state).
- A write is committed at the edge where its enable is sampled and is visible combinationally in the same cycle via bypass.
- Busy set is visible from the cycle after the `busy_set` edge. Busy clear is visible in the same cycle as `RUWr2`.
- `ready` is registered:
  - `CLEAR_ON_RESET=1`: rises `NREGS` edges after the first edge with `rst_n` high (32 cycles at default).
  - `CLEAR_ON_RESET=0`: rises 1 edge after the first edge with `rst_n` high.
- Reset values: `ready`=0, `rs1_busy`=`rs2_busy`=0, `RURs1`=`RURs2`=0, state INIT, `cnt`=0, all busy bits 0.

## Test plan
- **Reset/clear:** preload `reg[5]=0x1234` with `CLEAR_ON_RESET=1`, pulse `rst_n` low for 2 cycles, then release.
  - `ready` is 0 for 32 edges, then 1.
  - `rs1=5` reads 0x00000000.
  - Repeat with `CLEAR_ON_RESET=0`: `ready` after 1 edge, and `rs1=5` reads 0x1234.
- **x0:** `RUWr=1, rd=0, DataWr=0xDEADBEEF`, and `busy_set` with `busy_rd=0`, then read `rs1=0` -> `RURs1`=0 and `rs1_busy`=0.
- **Bypass:** in one cycle, `RUWr=1, rd=6, DataWr=0xDEADBEEF` with `rs1=6` -> `RURs1`=0xDEADBEEF in that same cycle. After the edge, with `RUWr=0`, it still reads 0xDEADBEEF.
- **Port conflict:** in one cycle, `RUWr=1, rd=7, DataWr=0xCAFEBABE` and `RUWr2=1, rd2=7, DataWr2=0x11111111` -> bypass and stored value are both 0xCAFEBABE.
- **Scoreboard:**
  - `busy_set` with `busy_rd=9` -> `rs2_busy`=1 next cycle with `rs2=9`.
  - `RUWr2=1, rd2=9, DataWr2=0x55` -> `rs2_busy`=0 and `RURs2`=0x55 in the same cycle.
  - Simultaneous set and clear on 9 -> busy stays 1.
- **Reset mid-INIT:** assert `rst_n` low at the 10th INIT edge -> `ready` stays 0, and rises exactly 32 edges after the re-release.
